// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared register map and helpers for the machine timer block
package clint_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0200_0000;

  localparam logic [5:0] MSIP_OFF        = 6'h00;
  localparam logic [5:0] MTIMECMP_LO_OFF = 6'h04;
  localparam logic [5:0] MTIMECMP_HI_OFF = 6'h08;
  localparam logic [5:0] MTIME_LO_OFF    = 6'h0C;
  localparam logic [5:0] MTIME_HI_OFF    = 6'h10;

  // All-ones compare value keeps the timer disarmed out of reset.
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// rtl/clint_prescaler.sv - tick generator, one o_tick cycle every PRESCALE clocks
module clint_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] count;

  assign o_tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (o_tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - mtime/mtimecmp/msip register window and interrupt outputs
module clint_timer
  import clint_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic            i_we,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [3:0]      i_wstrb,
  output logic            o_ack,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_timer_int,
  output logic            o_software_int
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        tick;

  logic        in_window;
  logic [5:0]  offset;
  logic        access;
  logic        wr;
  logic [31:0] rd_value;

  clint_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .o_tick(tick)
  );

  // The window is 64 bytes; only the upper address bits select it.
  assign in_window = (i_addr[XLEN-1:6] == BASE_ADDR[XLEN-1:6]);
  assign offset    = i_addr[5:0];
  assign access    = i_req && in_window;
  assign wr        = access && i_we;

  always_comb begin
    rd_value = '0;
    case (offset)
      MSIP_OFF:        rd_value = {31'b0, msip};
      MTIMECMP_LO_OFF: rd_value = mtimecmp[31:0];
      MTIMECMP_HI_OFF: rd_value = mtimecmp[63:32];
      MTIME_LO_OFF:    rd_value = mtime[31:0];
      MTIME_HI_OFF:    rd_value = mtime[63:32];
      default:         rd_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime          <= '0;
      mtimecmp       <= MTIMECMP_RESET;
      msip           <= 1'b0;
      o_ack          <= 1'b0;
      o_rdata        <= '0;
      o_timer_int    <= 1'b0;
      o_software_int <= 1'b0;
    end else begin
      o_ack   <= access;
      o_rdata <= (access && !i_we) ? rd_value : '0;

      if (wr && offset == MSIP_OFF && i_wstrb[0]) begin
        msip <= i_wdata[0];
      end
      if (wr && offset == MTIMECMP_LO_OFF) begin
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], i_wdata, i_wstrb);
      end
      if (wr && offset == MTIMECMP_HI_OFF) begin
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], i_wdata, i_wstrb);
      end

      // A store to either mtime half replaces this cycle's increment entirely.
      if (wr && offset == MTIME_LO_OFF) begin
        mtime[31:0] <= merge_bytes(mtime[31:0], i_wdata, i_wstrb);
      end else if (wr && offset == MTIME_HI_OFF) begin
        mtime[63:32] <= merge_bytes(mtime[63:32], i_wdata, i_wstrb);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      o_timer_int    <= (mtime >= mtimecmp);
      o_software_int <= msip;
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - directed self-checking bench for clint_timer
module tb_clint_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [3:0]  i_wstrb = '0;

  logic        o_ack, o_timer_int, o_software_int;
  logic [31:0] o_rdata;
  logic        ack4, tint4, sint4;
  logic [31:0] rdata4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clint_timer #(.XLEN(32), .PRESCALE(1), .BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req         (i_req),
    .i_we          (i_we),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .i_wstrb       (i_wstrb),
    .o_ack         (o_ack),
    .o_rdata       (o_rdata),
    .o_timer_int   (o_timer_int),
    .o_software_int(o_software_int)
  );

  clint_timer #(.XLEN(32), .PRESCALE(4), .BASE_ADDR(BASE)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .i_req         (i_req),
    .i_we          (i_we),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .i_wstrb       (i_wstrb),
    .o_ack         (ack4),
    .o_rdata       (rdata4),
    .o_timer_int   (tint4),
    .o_software_int(sint4)
  );

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic bus_load(input logic [31:0] off, output logic [31:0] d,
                          output logic [31:0] d4, output logic a);
    i_req = 1'b1; i_we = 1'b0; i_addr = BASE + off; i_wstrb = 4'hF; i_wdata = '0;
    @(posedge clk); #1;
    i_req = 1'b0;
    a = o_ack; d = o_rdata; d4 = rdata4;
  endtask

  task automatic bus_store(input logic [31:0] off, input logic [31:0] data,
                           input logic [3:0] strb);
    i_req = 1'b1; i_we = 1'b1; i_addr = BASE + off; i_wstrb = strb; i_wdata = data;
    @(posedge clk); #1;
    i_req = 1'b0; i_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", o_ack); end
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", o_rdata); end
    checks++; if (o_timer_int !== 1'b0) begin errors++; $display("FAIL reset_tint: got %b expected 0", o_timer_int); end
    checks++; if (o_software_int !== 1'b0) begin errors++; $display("FAIL reset_sint: got %b expected 0", o_software_int); end
  endtask

  task automatic test_mtime_count();
    logic [31:0] d, d4; logic a;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    bus_load(32'h0C, d, d4, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL count_ack: got %b expected 1", a); end
    checks++; if (d !== 32'd10) begin errors++; $display("FAIL count_mtime_lo: got %0d expected 10", d); end
    checks++; if (o_timer_int !== 1'b0) begin errors++; $display("FAIL count_tint: got %b expected 0", o_timer_int); end
    @(posedge clk); #1;
    checks++; if (o_ack !== 1'b0 || o_rdata !== 32'h0) begin errors++; $display("FAIL ack_single_cycle: got ack %b rdata %h expected 0 0", o_ack, o_rdata); end
    bus_load(32'h08, d, d4, a);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp_hi_reset: got %h expected ffffffff", d); end
  endtask

  task automatic test_timer_int();
    do_reset();
    bus_store(32'h08, 32'h0, 4'hF);
    bus_store(32'h04, 32'd40, 4'hF);
    repeat (38) @(posedge clk);
    #1;
    checks++; if (o_timer_int !== 1'b0) begin errors++; $display("FAIL tint_before: got %b expected 0", o_timer_int); end
    @(posedge clk); #1;
    checks++; if (o_timer_int !== 1'b1) begin errors++; $display("FAIL tint_rise: got %b expected 1", o_timer_int); end
    bus_store(32'h04, 32'd1000, 4'hF);
    checks++; if (o_timer_int !== 1'b1) begin errors++; $display("FAIL tint_hold: got %b expected 1", o_timer_int); end
    @(posedge clk); #1;
    checks++; if (o_timer_int !== 1'b0) begin errors++; $display("FAIL tint_fall: got %b expected 0", o_timer_int); end
  endtask

  task automatic test_mtime_carry();
    logic [31:0] d, d4; logic a;
    bus_store(32'h0C, 32'hFFFF_FFFE, 4'hF);
    bus_store(32'h10, 32'h0, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    bus_load(32'h0C, d, d4, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL carry_lo: got %h expected 0", d); end
    bus_load(32'h10, d, d4, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL carry_hi: got %h expected 1", d); end
    bus_store(32'h0C, 32'hFFFF_FFFF, 4'hF);
    bus_store(32'h10, 32'hFFFF_FFFF, 4'hF);
    bus_load(32'h0C, d, d4, a);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_lo_max: got %h expected ffffffff", d); end
    bus_load(32'h10, d, d4, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_hi: got %h expected 0", d); end
    bus_load(32'h0C, d, d4, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL wrap_lo: got %h expected 1", d); end
  endtask

  task automatic test_msip();
    logic [31:0] d, d4; logic a;
    bus_store(32'h00, 32'hFFFF_FFFF, 4'b0001);
    checks++; if (o_software_int !== 1'b0) begin errors++; $display("FAIL sint_early: got %b expected 0", o_software_int); end
    @(posedge clk); #1;
    checks++; if (o_software_int !== 1'b1) begin errors++; $display("FAIL sint_rise: got %b expected 1", o_software_int); end
    bus_load(32'h00, d, d4, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL msip_read: got %h expected 1", d); end
    bus_store(32'h00, 32'h0, 4'b1110);
    bus_load(32'h00, d, d4, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL msip_strb_ignored: got %h expected 1", d); end
    bus_store(32'h00, 32'h0, 4'b0001);
    @(posedge clk); #1;
    checks++; if (o_software_int !== 1'b0) begin errors++; $display("FAIL sint_fall: got %b expected 0", o_software_int); end
  endtask

  task automatic test_prescale();
    logic [31:0] d, d4; logic a;
    logic [31:0] exp_a [9] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
    logic [31:0] exp_b [5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h101};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus_load(32'h0C, d, d4, a);
      checks++; if (d4 !== exp_a[i]) begin errors++; $display("FAIL prescale_step%0d: got %0d expected %0d", i, d4, exp_a[i]); end
    end
    repeat (2) @(posedge clk);
    #1;
    bus_store(32'h0C, 32'h100, 4'hF);
    for (int i = 0; i < 5; i++) begin
      bus_load(32'h0C, d, d4, a);
      checks++; if (d4 !== exp_b[i]) begin errors++; $display("FAIL prescale_store%0d: got %h expected %h", i, d4, exp_b[i]); end
    end
  endtask

  task automatic test_strobes_and_reset();
    logic [31:0] d, d4; logic a;
    do_reset();
    bus_store(32'h04, 32'hAABB_CCDD, 4'b0010);
    bus_load(32'h04, d, d4, a);
    checks++; if (d !== 32'hFFFF_CCFF) begin errors++; $display("FAIL cmp_lo_byte1: got %h expected ffffccff", d); end
    bus_load(32'h20, d, d4, a);
    checks++; if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_load: got ack %b rdata %h expected 1 0", a, d); end
    bus_load(32'h40, d, d4, a);
    checks++; if (a !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL outside_window: got ack %b rdata %h expected 0 0", a, d); end
    bus_store(32'h00, 32'h1, 4'b0001);
    repeat (2) @(posedge clk);
    #1;
    i_req = 1'b1; i_we = 1'b0; i_addr = BASE + 32'h04; i_wstrb = 4'hF;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; i_req = 1'b0;
    checks++; if (o_ack !== 1'b0 || o_rdata !== 32'h0) begin errors++; $display("FAIL reset_req_ack: got ack %b rdata %h expected 0 0", o_ack, o_rdata); end
    checks++; if (o_software_int !== 1'b0) begin errors++; $display("FAIL reset_req_sint: got %b expected 0", o_software_int); end
    bus_load(32'h0C, d, d4, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mtime: got %h expected 0", d); end
    bus_load(32'h04, d, d4, a);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_lo: got %h expected ffffffff", d); end
    bus_load(32'h08, d, d4, a);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi: got %h expected ffffffff", d); end
    bus_load(32'h00, d, d4, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_msip: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_mtime_count();
    test_timer_int();
    test_mtime_carry();
    test_msip();
    test_prescale();
    test_strobes_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
